// File: rtl/turn_input_conditioner.sv
// Conditions the two turn-signal switches: synchronizes each raw input, debounces it
// into a clean level, and derives the hazard request and a one-cycle change pulse.
module turn_input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic L_raw,
  input  logic R_raw,
  output logic L,
  output logic R,
  output logic hz,
  output logic chg
);

  localparam int NCH = 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] clean_vec;
  logic [NCH-1:0] change_vec;
  logic           chg_q;
  logic           chg_d;

  // Channel 0 is left, channel 1 is right.
  assign raw = {R_raw, L_raw};

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic          s1_q;
      logic          s1_d;
      logic          s2_q;
      logic          s2_d;
      logic          clean_q;
      logic          clean_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        s1_d    = raw[gi];
        s2_d    = s1_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        if (s2_q == clean_q) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          // Saturating compare keeps the counter from ever wrapping.
          clean_d = s2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          clean_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          clean_q <= clean_d;
          cnt_q   <= cnt_d;
        end
      end

      assign clean_vec[gi]  = clean_q;
      assign change_vec[gi] = clean_d ^ clean_q;
    end
  endgenerate

  // Registered alongside the clean values so the pulse coincides with the new level.
  always_comb begin
    chg_d = |change_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign L   = clean_vec[0];
  assign R   = clean_vec[1];
  assign hz  = clean_vec[0] & clean_vec[1];
  assign chg = chg_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed scoreboard bench for turn_input_conditioner at default parameters.
module tb_turn_input_conditioner;

  logic clk;
  logic reset;
  logic L_raw;
  logic R_raw;
  logic L;
  logic R;
  logic hz;
  logic chg;

  logic [3:0] exp_q[$];
  string      name_q[$];
  int         n_tests;
  int         n_fail;

  turn_input_conditioner #(.DB_CYCLES(4), .CW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .L_raw(L_raw),
    .R_raw(R_raw),
    .L    (L),
    .R    (R),
    .hz   (hz),
    .chg  (chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic lr, input logic rr, input logic rst,
                      input logic el, input logic er, input logic ec,
                      input string nm);
    @(negedge clk);
    L_raw = lr;
    R_raw = rr;
    reset = rst;
    exp_q.push_back({el, er, el & er, ec});
    name_q.push_back(nm);
  endtask

  // Monitor: compares outputs just after each edge against the queued expectation.
  initial begin
    logic [3:0] got;
    logic [3:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        got = {L, R, hz, chg};
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got L,R,hz,chg=%b required %b", nm, got, e);
        end else begin
          $display("[TB] ok %s L,R,hz,chg=%b", nm, got);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    L_raw   = 1'b0;
    R_raw   = 1'b0;

    // Reset and idle
    step(0, 0, 1, 0, 0, 0, "reset");
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, "idle");

    // Left held 10 cycles: rises after the 6th edge (index 5), then release
    for (int i = 0; i < 10; i++) step(1, 0, 0, i >= 5, 0, i == 5, "left_rise");
    for (int i = 0; i < 8; i++)  step(0, 0, 0, i < 5, 0, i == 5, "left_fall");

    // 3-cycle pulse is rejected
    for (int i = 0; i < 3; i++)  step(1, 0, 0, 0, 0, 0, "left_glitch3");
    for (int i = 0; i < 8; i++)  step(0, 0, 0, 0, 0, 0, "left_glitch3_after");

    // 4-cycle pulse is the shortest that passes
    for (int i = 0; i < 12; i++)
      step(i < 4, 0, 0, (i >= 5) && (i < 9), 0, (i == 5) || (i == 9), "left_pulse4");

    // Both together: same-edge rise, hazard, single pulse
    for (int i = 0; i < 8; i++)  step(1, 1, 0, i >= 5, i >= 5, i == 5, "both_rise");
    for (int i = 0; i < 7; i++)  step(0, 0, 0, i < 5, i < 5, i == 5, "both_fall");

    // Staggered: independent channels
    for (int i = 0; i < 10; i++)
      step(1, i >= 2, 0, i >= 5, i >= 7, (i == 5) || (i == 7), "stagger_rise");
    for (int i = 0; i < 8; i++)  step(0, 0, 0, i < 5, i < 5, i == 5, "stagger_fall");

    // Right: high 3, low 1, high 6, then low; the gap restarts the count
    begin
      logic [17:0] pat;
      pat = 18'b00000000_1111110111;
      for (int i = 0; i < 18; i++)
        step(0, pat[i], 0, 0, (i >= 9) && (i < 15), (i == 9) || (i == 15), "right_restart");
    end

    // Right held; reset mid-settling discards the partial count
    for (int i = 0; i < 15; i++)
      step(0, 1, i == 4, 0, i >= 10, i == 10, "right_reset_mid");
    for (int i = 0; i < 7; i++)  step(0, 0, 0, 0, i < 5, i == 5, "right_reset_fall");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
